// File: rtl/regfile_sb_if.sv
// rtl/regfile_sb_if.sv - writeback, read, issue and status signals of the scoreboarded register file
interface regfile_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic [ADDR_W-1:0] raddr1;
    logic [ADDR_W-1:0] raddr2;
    logic [DATA_W-1:0] rdata1;
    logic [DATA_W-1:0] rdata2;
    logic              issue;
    logic [ADDR_W-1:0] issue_addr;
    logic              busy1;
    logic              busy2;
    logic              stall;
    logic [ADDR_W:0]   pend_cnt;
    logic              err_clr;
    logic              wr_err;

    modport master (
        output we, waddr, wdata, raddr1, raddr2, issue, issue_addr, err_clr,
        input  rdata1, rdata2, busy1, busy2, stall, pend_cnt, wr_err
    );

    modport slave (
        input  we, waddr, wdata, raddr1, raddr2, issue, issue_addr, err_clr,
        output rdata1, rdata2, busy1, busy2, stall, pend_cnt, wr_err
    );
endinterface

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - register file with pending-producer scoreboard, write protection and bypass
module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int PROT_EN  = 1,
    parameter int PROT_REG = 31,
    parameter int BYPASS   = 1
) (
    input  logic         clk,
    input  logic         rst,
    regfile_sb_if.slave  bus
);
    localparam int                DEPTH    = 2 ** ADDR_W;
    localparam int                CW       = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] PROT_IDX = ADDR_W'(PROT_REG);

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0]  busy_q, busy_d;
    logic [CW-1:0]     pend_cnt_q, pend_cnt_d;
    logic              wr_err_q, wr_err_d;

    logic prot_hit, zero_hit, wr_elig, issue_eff, inc, dec;

    always_comb begin
        prot_hit  = (PROT_EN != 0) && (bus.waddr == PROT_IDX);
        zero_hit  = (ZERO_REG != 0) && (bus.waddr == '0);
        wr_elig   = bus.we && !zero_hit && !prot_hit;
        issue_eff = bus.issue && !((ZERO_REG != 0) && (bus.issue_addr == '0));
    end

    // A same-index issue overrides the writeback clear, so no decrement then.
    always_comb begin
        busy_d = busy_q;
        if (bus.we)
            busy_d[bus.waddr] = 1'b0;
        if (issue_eff)
            busy_d[bus.issue_addr] = 1'b1;
        inc = issue_eff && !busy_q[bus.issue_addr];
        dec = bus.we && busy_q[bus.waddr] && !(issue_eff && (bus.issue_addr == bus.waddr));
        pend_cnt_d = pend_cnt_q + CW'(inc) - CW'(dec);
    end

    always_comb begin
        wr_err_d = wr_err_q;
        if (bus.we && prot_hit)
            wr_err_d = 1'b1;
        else if (bus.err_clr)
            wr_err_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++)
                regs_q[i] <= '0;
            busy_q     <= '0;
            pend_cnt_q <= '0;
            wr_err_q   <= 1'b0;
        end else begin
            if (wr_elig)
                regs_q[bus.waddr] <= bus.wdata;
            busy_q     <= busy_d;
            pend_cnt_q <= pend_cnt_d;
            wr_err_q   <= wr_err_d;
        end
    end

    always_comb begin
        bus.rdata1 = regs_q[bus.raddr1];
        if ((BYPASS != 0) && wr_elig && (bus.waddr == bus.raddr1))
            bus.rdata1 = bus.wdata;
        if ((ZERO_REG != 0) && (bus.raddr1 == '0))
            bus.rdata1 = '0;

        bus.rdata2 = regs_q[bus.raddr2];
        if ((BYPASS != 0) && wr_elig && (bus.waddr == bus.raddr2))
            bus.rdata2 = bus.wdata;
        if ((ZERO_REG != 0) && (bus.raddr2 == '0))
            bus.rdata2 = '0;
    end

    // Busy is masked by any writeback to the same index, even a discarded one.
    always_comb begin
        bus.busy1 = busy_q[bus.raddr1]
                    && !((BYPASS != 0) && bus.we && (bus.waddr == bus.raddr1))
                    && !((ZERO_REG != 0) && (bus.raddr1 == '0));
        bus.busy2 = busy_q[bus.raddr2]
                    && !((BYPASS != 0) && bus.we && (bus.waddr == bus.raddr2))
                    && !((ZERO_REG != 0) && (bus.raddr2 == '0));
        bus.stall    = bus.busy1 || bus.busy2;
        bus.pend_cnt = pend_cnt_q;
        bus.wr_err   = wr_err_q;
    end
endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - self-checking bench for regfile_sb with a behavioural reference model
module tb_regfile_sb;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    regfile_sb_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    regfile_sb dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    logic [31:0] m_regs [32];
    bit          m_busy [32];
    bit          m_err;

    function automatic int m_pend();
        int n = 0;
        for (int i = 0; i < 32; i++)
            if (m_busy[i]) n++;
        return n;
    endfunction

    function automatic logic [31:0] m_rd(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (bus.we && bus.waddr == a && bus.waddr != 31) return bus.wdata;
        return m_regs[a];
    endfunction

    function automatic logic m_bsy(input logic [4:0] a);
        return (a != 0) && m_busy[a] && !(bus.we && bus.waddr == a);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        #1;
        chk({tag, ":rdata1"}, 64'(bus.rdata1), 64'(m_rd(bus.raddr1)));
        chk({tag, ":rdata2"}, 64'(bus.rdata2), 64'(m_rd(bus.raddr2)));
        chk({tag, ":busy1"}, 64'(bus.busy1), 64'(m_bsy(bus.raddr1)));
        chk({tag, ":busy2"}, 64'(bus.busy2), 64'(m_bsy(bus.raddr2)));
        chk({tag, ":stall"}, 64'(bus.stall), 64'(m_bsy(bus.raddr1) | m_bsy(bus.raddr2)));
        chk({tag, ":pend_cnt"}, 64'(bus.pend_cnt), 64'(m_pend()));
        chk({tag, ":wr_err"}, 64'(bus.wr_err), 64'(m_err));
    endtask

    task automatic model_edge();
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                m_regs[i] = 32'h0;
                m_busy[i] = 1'b0;
            end
            m_err = 1'b0;
        end else begin
            if (bus.we && bus.waddr != 0 && bus.waddr != 31) m_regs[bus.waddr] = bus.wdata;
            if (bus.we) m_busy[bus.waddr] = 1'b0;
            if (bus.issue && bus.issue_addr != 0) m_busy[bus.issue_addr] = 1'b1;
            if (bus.we && bus.waddr == 31) m_err = 1'b1;
            else if (bus.err_clr) m_err = 1'b0;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.we = 0; bus.waddr = 0; bus.wdata = 0;
        bus.issue = 0; bus.issue_addr = 0; bus.err_clr = 0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        bus.we = 1; bus.waddr = a; bus.wdata = d;
    endtask

    initial begin
        idle();
        bus.raddr1 = 0; bus.raddr2 = 0;
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = $urandom; m_busy[i] = 1'b1;
        end
        m_err = 1'b1;
        rst = 0;
        wr(5, 32'h1111); bus.issue = 1; bus.issue_addr = 6; bus.err_clr = 1;
        tick();
        tick();
        idle();
        rst = 1;
        bus.raddr1 = 5; bus.raddr2 = 6;
        check_all("reset");
        chk("reset:r5", 64'(bus.rdata1), 64'h0);

        wr(5, 32'hDEADBEEF); check_all("w5"); tick();
        idle(); bus.raddr1 = 5; check_all("r5");
        chk("r5_lit", 64'(bus.rdata1), 64'hDEADBEEF);
        wr(0, 32'h1234); bus.raddr1 = 0; check_all("w0"); tick();
        idle(); check_all("r0");
        chk("r0_lit", 64'(bus.rdata1), 64'h0);

        wr(7, 32'hA5A5A5A5); bus.raddr2 = 7; check_all("byp7");
        chk("byp7_lit", 64'(bus.rdata2), 64'hA5A5A5A5);
        chk("byp7_busy", 64'(bus.busy2), 64'h0);
        tick();

        idle(); bus.issue = 1; bus.issue_addr = 3; check_all("iss3"); tick();
        idle(); bus.raddr1 = 3; check_all("busy3");
        chk("busy3_lit", 64'(bus.stall), 64'h1);
        chk("pend1_lit", 64'(bus.pend_cnt), 64'h1);
        wr(3, 32'h33); check_all("wb3"); tick();
        idle(); check_all("clr3");
        chk("pend0_lit", 64'(bus.pend_cnt), 64'h0);

        idle(); bus.issue = 1; bus.issue_addr = 9; tick();
        wr(9, 32'h99); bus.issue = 1; bus.issue_addr = 9; bus.raddr1 = 9; check_all("iw9"); tick();
        idle(); check_all("iw9_after");
        chk("iw9_busy", 64'(bus.busy1), 64'h1);
        chk("iw9_data", 64'(bus.rdata1), 64'h99);
        wr(9, 32'h0); tick();
        idle();

        bus.raddr2 = 31;
        wr(31, 32'hFFFFFFFF); check_all("w31"); tick();
        idle(); check_all("err1");
        chk("err_lit", 64'(bus.wr_err), 64'h1);
        tick(); check_all("err_hold");
        bus.err_clr = 1; wr(31, 32'h5); check_all("err_set_wins"); tick();
        idle(); check_all("err_still");
        bus.err_clr = 1; tick();
        idle(); check_all("err_clr");

        for (int k = 0; k < 400; k++) begin
            bus.we = ($urandom_range(0, 1) == 1);
            bus.waddr = 5'($urandom_range(0, 31));
            bus.wdata = $urandom;
            bus.issue = ($urandom_range(0, 2) != 0);
            bus.issue_addr = ($urandom_range(0, 3) == 0) ? bus.waddr : 5'($urandom_range(0, 31));
            bus.err_clr = ($urandom_range(0, 7) == 0);
            bus.raddr1 = ($urandom_range(0, 2) == 0) ? bus.waddr : 5'($urandom_range(0, 31));
            bus.raddr2 = 5'($urandom_range(0, 31));
            rst = ($urandom_range(0, 99) != 0);
            check_all("rand");
            tick();
        end
        rst = 1;

        idle();
        bus.issue = 1; bus.issue_addr = 1; tick();
        bus.issue_addr = 2; tick();
        bus.issue_addr = 4; tick();
        idle(); wr(31, 32'h7); tick();
        idle(); wr(1, 32'hCAFE); rst = 0; tick();
        idle(); rst = 1; bus.raddr1 = 1; bus.raddr2 = 2;
        check_all("rst_mid");
        chk("rst_pend", 64'(bus.pend_cnt), 64'h0);
        chk("rst_stall", 64'(bus.stall), 64'h0);
        chk("rst_err", 64'(bus.wr_err), 64'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter DATA_W, default 32, register width in bits.
REQ-002 Parameter ADDR_W, default 5, address width; DEPTH = 2**ADDR_W registers.
REQ-003 Parameter ZERO_REG, default 1, register 0 hardwired to zero when 1.
REQ-004 Parameter PROT_EN, default 1, enables write protection of register PROT_REG.
REQ-005 Parameter PROT_REG, default 31, index of the write-protected register.
REQ-006 Parameter BYPASS, default 1, enables same-cycle write-to-read forwarding.
REQ-007 clk  input  1  sole clock; all state updates on rising edge.
REQ-008 rst  input  1  synchronous, active-low reset.
REQ-009 we  input  1  writeback valid.
REQ-010 waddr  input  ADDR_W  writeback register index.
REQ-011 wdata  input  DATA_W  writeback data.
REQ-012 raddr1, raddr2  input  ADDR_W  read port indices.
REQ-013 rdata1, rdata2  output  DATA_W  read data, combinational.
REQ-014 issue  input  1  marks issue_addr as pending producer.
REQ-015 issue_addr  input  ADDR_W  destination being issued.
REQ-016 busy1, busy2  output  1  source register pending, combinational.
REQ-017 stall  output  1  busy1 OR busy2.
REQ-018 pend_cnt  output  ADDR_W+1  number of busy registers, registered.
REQ-019 err_clr  input  1  clears wr_err.
REQ-020 wr_err  output  1  sticky protected-write error, registered.

Function
REQ-021 Write eligible = we AND NOT (ZERO_REG AND waddr==0) AND NOT (PROT_EN AND waddr==PROT_REG).
REQ-022 Eligible write stores wdata into register waddr at rising edge; ineligible write is discarded, no state change to array.
REQ-023 Read of index 0 with ZERO_REG=1 returns 0 regardless of any write.
REQ-024 BYPASS=1: eligible write with waddr==raddrN drives rdataN = wdata in same cycle; BYPASS=0: rdataN shows pre-edge contents.
REQ-025 Scoreboard: one busy bit per register, cleared at reset.
REQ-026 issue sets busy[issue_addr] at edge; ignored for index 0 when ZERO_REG=1.
REQ-027 we clears busy[waddr] at edge, including discarded writes to PROT_REG.
REQ-028 Simultaneous issue and we to same index: set wins, busy stays 1.
REQ-029 Issue to already-busy register: busy stays 1, pend_cnt unchanged.
REQ-030 busyN = busy[raddrN] AND NOT (BYPASS AND we AND waddr==raddrN); index 0 with ZERO_REG=1 never busy.
REQ-031 pend_cnt updated incrementally: +1 per 0->1 busy transition, -1 per 1->0, net of both in one cycle; never wraps (max DEPTH).
REQ-032 wr_err set at edge when we AND PROT_EN AND waddr==PROT_REG; cleared by err_clr; set wins over err_clr same cycle.

Reset
REQ-033 rst low at rising edge: all registers 0, all busy bits 0, pend_cnt 0, wr_err 0.
REQ-034 Reset overrides we, issue and err_clr in the same cycle; first writes/issues accepted on first edge with rst high.

Verification
REQ-035 Reset, write 0xDEADBEEF to r5, read raddr1=5 next cycle -> rdata1=0xDEADBEEF; write 0x1234 to r0 -> r0 reads 0.
REQ-036 we=1 waddr=7 wdata=0xA5A5A5A5, raddr2=7 same cycle, BYPASS=1 -> rdata2=0xA5A5A5A5 combinationally, busy2=0.
REQ-037 issue r3, next cycle raddr1=3 -> busy1=1, stall=1, pend_cnt=1; we r3 -> next cycle busy1=0, pend_cnt=0.
REQ-038 issue and we both r9 same cycle with r9 busy -> r9 stays busy, pend_cnt unchanged, r9 holds new data.
REQ-039 we to r31 with 0xFFFFFFFF -> r31 unchanged, wr_err=1 held until err_clr; err_clr with new r31 write -> wr_err stays 1.
REQ-040 Issue r1,r2,r4 then assert rst low during a we to r1 -> all regs 0, pend_cnt 0, wr_err 0, stall 0.
